// File: rtl/shared_slow_memory.sv
// shared_slow_memory
//   Line-based slow memory shared by NUM_PORTS requesters. A round-robin
//   arbiter grants one port at a time. After LATENCY wait cycles the access
//   is performed, and the granted port then gets a one-cycle ready pulse.
//   Saturating statistics count completed reads and writes, and contention
//   cycles.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   mem_read/mem_write  per-port request bits, held until that port's ready
//   mem_addr            per-port line address, port p at [p*ADDR_W +: ADDR_W]
//   mem_wdata           per-port write line, port p at [p*LINE_W +: LINE_W]
//   mem_rdata           per-port registered read line
//   mem_ready           per-port one-cycle completion pulse
//   busy                high while an access is in progress
//   stat_reads/writes   completed reads / writes (saturating)
//   stat_conflicts      busy cycles with another port waiting (saturating)
module shared_slow_memory #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        mem_read,
  input  logic [NUM_PORTS-1:0]        mem_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] mem_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] mem_wdata,
  output logic [NUM_PORTS*LINE_W-1:0] mem_rdata,
  output logic [NUM_PORTS-1:0]        mem_ready,
  output logic                        busy,
  output logic [31:0]                 stat_reads,
  output logic [31:0]                 stat_writes,
  output logic [31:0]                 stat_conflicts
);

  localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  if (NUM_PORTS < 1) begin : g_chk_ports
    $error("shared_slow_memory: NUM_PORTS must be >= 1");
  end
  if (LATENCY < 1) begin : g_chk_lat
    $error("shared_slow_memory: LATENCY must be >= 1");
  end
  if (DEPTH_LOG2 > ADDR_W) begin : g_chk_depth
    $error("shared_slow_memory: DEPTH_LOG2 must not exceed ADDR_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [PW-1:0]             gnt_q;
  logic [PW-1:0]             rr_q;
  logic [DEPTH_LOG2-1:0]     idx_q;
  logic [LINE_W-1:0]         wdata_q;
  logic                      wr_q;
  logic [NUM_PORTS*LINE_W-1:0] rdata_q;
  logic [NUM_PORTS-1:0]      ready_q;
  logic [31:0]               reads_q;
  logic [31:0]               writes_q;
  logic [31:0]               conflicts_q;

  logic [LINE_W-1:0]         mem_q [DEPTH];

  logic [NUM_PORTS-1:0]      req;
  logic [PW-1:0]             cand;
  logic                      gnt_vld_d;
  logic [PW-1:0]             gnt_d;
  logic [DEPTH_LOG2-1:0]     sel_idx_d;
  logic [LINE_W-1:0]         sel_wdata_d;
  logic                      sel_wr_d;
  logic                      other_req_d;
  logic                      commit_d;
  logic                      unused_addr;

  assign req = mem_read | mem_write;

  // Only the index bits of each address are stored; upper bits alias.
  assign unused_addr = ^mem_addr;

  // Round-robin search: first requesting port at or above rr_q, wrapping.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_d     = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((32'(rr_q) + i) % NUM_PORTS);
      if (!gnt_vld_d && req[cand]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = cand;
      end
    end
  end

  // Fields of the port that would be granted this cycle.
  always_comb begin
    sel_idx_d   = '0;
    sel_wdata_d = '0;
    sel_wr_d    = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (PW'(i) == gnt_d) begin
        sel_idx_d   = mem_addr[i*ADDR_W +: DEPTH_LOG2];
        sel_wdata_d = mem_wdata[i*LINE_W +: LINE_W];
        sel_wr_d    = mem_write[i];
      end
    end
  end

  always_comb begin
    other_req_d = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && (PW'(i) != gnt_q)) other_req_d = 1'b1;
    end
  end

  assign commit_d = (state_q == S_WAIT) && (cnt_q == '0);

  // Array has no reset; a reset in the commit cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit_d && wr_q) mem_q[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rr_q        <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= '0;
      reads_q     <= '0;
      writes_q    <= '0;
      conflicts_q <= '0;
    end else begin
      ready_q <= '0;
      if ((state_q != S_IDLE) && other_req_d && (conflicts_q != '1)) begin
        conflicts_q <= conflicts_q + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            gnt_q   <= gnt_d;
            idx_q   <= sel_idx_d;
            wdata_q <= sel_wdata_d;
            wr_q    <= sel_wr_d;
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
              if (PW'(i) == gnt_q) begin
                ready_q[i] <= 1'b1;
                if (!wr_q) rdata_q[i*LINE_W +: LINE_W] <= mem_q[idx_q];
              end
            end
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (wr_q) begin
            if (writes_q != '1) writes_q <= writes_q + 32'd1;
          end else begin
            if (reads_q != '1) reads_q <= reads_q + 32'd1;
          end
          rr_q    <= (gnt_q == PW'(NUM_PORTS - 1)) ? '0 : gnt_q + PW'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rdata      = rdata_q;
  assign mem_ready      = ready_q;
  assign busy           = (state_q != S_IDLE);
  assign stat_reads     = reads_q;
  assign stat_writes    = writes_q;
  assign stat_conflicts = conflicts_q;

endmodule

// File: tb/tb_shared_slow_memory.sv
// Self-checking bench for shared_slow_memory: a LATENCY=4 instance (u4) and a
// LATENCY=1 instance (u1) share the request inputs; each is held in reset
// while the other is being exercised.
module tb_shared_slow_memory;

  localparam int NP = 2;
  localparam int AW = 28;
  localparam int LW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst1;
  logic [NP-1:0]    rd, wr;
  logic [NP*AW-1:0] addr;
  logic [NP*LW-1:0] wdata;

  logic [NP*LW-1:0] rdata4, rdata1;
  logic [NP-1:0]    ready4, ready1;
  logic             busy4, busy1;
  logic [31:0]      sr4, sw4, sc4, sr1, sw1, sc1;

  shared_slow_memory #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW),
                       .DEPTH_LOG2(10), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst4), .mem_read(rd), .mem_write(wr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata4), .mem_ready(ready4), .busy(busy4),
    .stat_reads(sr4), .stat_writes(sw4), .stat_conflicts(sc4));

  shared_slow_memory #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW),
                       .DEPTH_LOG2(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst1), .mem_read(rd), .mem_write(wr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata1), .mem_ready(ready1), .busy(busy1),
    .stat_reads(sr1), .stat_writes(sw1), .stat_conflicts(sc1));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int             port;
    bit             r;
    bit             w;
    logic [AW-1:0]  a;
    logic [LW-1:0]  d;
    logic [LW-1:0]  exp;   // that port's rdata after completion
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP-1:0] rdy(input bit s);
    return s ? ready1 : ready4;
  endfunction

  function automatic logic [LW-1:0] rdline(input bit s, input int p);
    logic [NP*LW-1:0] t;
    t = s ? rdata1 : rdata4;
    return t[p*LW +: LW];
  endfunction

  // Drive one request on port p, wait (bounded) for its ready, drop it.
  task automatic do_access(input bit s, input int p, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [LW-1:0] d,
                           output int lat);
    logic [NP-1:0] rr;
    addr[p*AW +: AW]  = a;
    wdata[p*LW +: LW] = d;
    rd[p] = r;
    wr[p] = w;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      rr = rdy(s);
      if (rr[p]) begin
        lat = n;
        check("ready_onehot", 128'(rr), 128'(NP'(1) << p));
        break;
      end
    end
    rd[p] = 1'b0;
    wr[p] = 1'b0;
    tick();
    check("ready_pulse_width", 128'(rdy(s)), 128'd0);
  endtask

  initial begin
    int lat;
    int t0, t1, ng;
    int order [6];
    int when [6];
    bit pend [NP];
    logic [NP-1:0] rr;

    tbl[0] = '{0, 1'b0, 1'b1, 28'h5,    {16{8'hA5}}, 128'h0};
    tbl[1] = '{0, 1'b1, 1'b0, 28'h5,    128'h0,      {16{8'hA5}}};
    tbl[2] = '{1, 1'b0, 1'b1, 28'h3FF,  128'h1234,   128'h0};
    tbl[3] = '{1, 1'b1, 1'b0, 28'h7FF,  128'h0,      128'h1234};
    tbl[4] = '{0, 1'b1, 1'b1, 28'h2,    128'hBEEF,   {16{8'hA5}}};
    tbl[5] = '{1, 1'b1, 1'b0, 28'h2,    128'h0,      128'hBEEF};
    tbl[6] = '{0, 1'b0, 1'b1, 28'h7,    128'h0,      {16{8'hA5}}};
    tbl[7] = '{0, 1'b1, 1'b0, 28'h7,    128'h0,      128'h0};
    tbl[8] = '{1, 1'b0, 1'b1, 28'h405,  128'hDEAD,   128'hBEEF};
    tbl[9] = '{0, 1'b1, 1'b0, 28'h5,    128'h0,      128'hDEAD};

    rst4 = 1'b1; rst1 = 1'b1;
    rd = '0; wr = '0; addr = '0; wdata = '0;
    tick(); tick();
    rst4 = 1'b0;
    tick();

    // Reset state of u4
    check("rst_ready", 128'(ready4), 128'd0);
    check("rst_rdata0", rdline(0, 0), 128'd0);
    check("rst_rdata1", rdline(0, 1), 128'd0);
    check("rst_busy", 128'(busy4), 128'd0);
    check("rst_reads", 128'(sr4), 128'd0);
    check("rst_writes", 128'(sw4), 128'd0);
    check("rst_conflicts", 128'(sc4), 128'd0);

    // Table of single accesses, LATENCY=4
    for (int i = 0; i < 10; i++) begin
      do_access(0, tbl[i].port, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd5);
      check($sformatf("vec%0d_rdata", i), rdline(0, tbl[i].port), tbl[i].exp);
    end
    check("tbl_reads", 128'(sr4), 128'd5);
    check("tbl_writes", 128'(sw4), 128'd5);
    check("tbl_conflicts", 128'(sc4), 128'd0);
    check("tbl_rdata1_hold", rdline(0, 1), 128'hBEEF);

    // Contention from reset: both ports read in the same cycle
    rst4 = 1'b1; tick(); tick(); rst4 = 1'b0;
    addr[0 +: AW] = 28'h5;
    addr[AW +: AW] = 28'h2;
    rd = 2'b11;
    t0 = -1; t1 = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ready4[0] && t0 < 0) begin t0 = c; rd[0] = 1'b0; end
      if (ready4[1] && t1 < 0) begin t1 = c; rd[1] = 1'b0; end
      if (t0 >= 0 && t1 >= 0) break;
    end
    rd = '0;
    tick();
    check("cont_ready0_cycle", 128'(t0), 128'd5);
    check("cont_ready1_cycle", 128'(t1), 128'd11);
    check("cont_conflicts", 128'(sc4), 128'd5);
    check("cont_reads", 128'(sr4), 128'd2);
    check("cont_rdata0", rdline(0, 0), 128'hDEAD);
    check("cont_rdata1", rdline(0, 1), 128'hBEEF);

    // Fairness: both ports re-request the cycle after each ready
    ng = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    rd = 2'b11;
    for (int c = 1; c <= 60 && ng < 6; c++) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        if (pend[p]) begin rd[p] = 1'b1; pend[p] = 1'b0; end
      end
      rr = ready4;
      for (int p = 0; p < NP; p++) begin
        if (rr[p] && ng < 6) begin
          order[ng] = p; when[ng] = c; ng++;
          rd[p] = 1'b0; pend[p] = 1'b1;
        end
      end
    end
    rd = '0;
    check("fair_count", 128'(ng), 128'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < ng) begin
        check($sformatf("fair_port%0d", k), 128'(order[k]), 128'(k % 2));
        check($sformatf("fair_cycle%0d", k), 128'(when[k]), 128'(5 + 6 * k));
      end
    end
    tick(); tick();

    // Reset during WAIT of a write to addr 7: no commit, no ready, rdata cleared
    addr[0 +: AW] = 28'h7;
    wdata[0 +: LW] = 128'hFFFF;
    wr[0] = 1'b1;
    tick(); tick();
    rst4 = 1'b1;
    wr[0] = 1'b0;
    tick();
    check("rstwait_busy", 128'(busy4), 128'd0);
    check("rstwait_ready", 128'(ready4), 128'd0);
    check("rstwait_rdata0", rdline(0, 0), 128'd0);
    rst4 = 1'b0;
    t0 = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ready4 != '0) t0++;
    end
    check("rstwait_no_ready", 128'(t0), 128'd0);
    do_access(0, 0, 1'b1, 1'b0, 28'h7, 128'h0, lat);
    check("rstwait_read_lat", 128'(lat), 128'd5);
    check("rstwait_read_data", rdline(0, 0), 128'd0);
    check("rstwait_reads", 128'(sr4), 128'd1);
    check("rstwait_writes", 128'(sw4), 128'd0);

    // Reset during RESP of a write: ready drops, committed data stands
    addr[AW +: AW] = 28'h9;
    wdata[LW +: LW] = 128'h99;
    wr[1] = 1'b1;
    t0 = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ready4[1]) begin t0 = c; break; end
    end
    check("rstresp_ready_cycle", 128'(t0), 128'd5);
    rst4 = 1'b1;
    wr[1] = 1'b0;
    tick();
    check("rstresp_ready_clr", 128'(ready4), 128'd0);
    rst4 = 1'b0;
    tick();
    do_access(0, 1, 1'b1, 1'b0, 28'h9, 128'h0, lat);
    check("rstresp_read_data", rdline(0, 1), 128'h99);

    // LATENCY=1 instance
    rst4 = 1'b1;
    rd = '0; wr = '0;
    tick();
    rst1 = 1'b0;
    tick();
    check("l1_rst_busy", 128'(busy1), 128'd0);
    check("l1_rst_rdata0", rdline(1, 0), 128'd0);
    do_access(1, 0, 1'b0, 1'b1, 28'h3, 128'h0, lat);
    check("l1_write_lat", 128'(lat), 128'd2);
    addr[0 +: AW] = 28'h3;
    wdata[0 +: LW] = 128'h77;
    wr[0] = 1'b1;
    tick();
    rst1 = 1'b1;
    wr[0] = 1'b0;
    tick();
    check("l1_rstwait_busy", 128'(busy1), 128'd0);
    check("l1_rstwait_ready", 128'(ready1), 128'd0);
    rst1 = 1'b0;
    tick();
    do_access(1, 0, 1'b1, 1'b0, 28'h3, 128'h0, lat);
    check("l1_read_lat", 128'(lat), 128'd2);
    check("l1_read_nocommit", rdline(1, 0), 128'd0);
    do_access(1, 1, 1'b0, 1'b1, 28'h3, 128'h55, lat);
    do_access(1, 1, 1'b1, 1'b0, 28'h3, 128'h0, lat);
    check("l1_read2_lat", 128'(lat), 128'd2);
    check("l1_read2_data", rdline(1, 1), 128'h55);
    check("l1_reads", 128'(sr1), 128'd2);
    check("l1_writes", 128'(sw1), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
